// File: rtl/shared_counters_pkg.sv
// Shared types for the shared counter pool: command codes, read FSM states and default sizing.
package shared_counters_pkg;
  localparam int N_DEF = 10;
  localparam int G_DEF = 4;
  localparam int ID_W  = $clog2(N_DEF);

  typedef enum logic [2:0] {
    CMD_IDLE    = 3'b000,
    CMD_INC     = 3'b001,
    CMD_NEW     = 3'b010,
    CMD_DEALLOC = 3'b011,
    CMD_LOAD    = 3'b100,
    CMD_READ    = 3'b101
  } cmd_t;

  typedef enum logic [1:0] {RD_IDLE, RD_BURST, RD_HOLD} rd_state_t;
endpackage

// File: rtl/shared_counters_core_slice_allocator.sv
// Combinational first-fit search over the free-slice mask, plus lowest free counter id.
module slice_allocator #(
  parameter int n = 10
) (
  input  logic [n-1:0]         free_mask,
  input  logic [n-1:0]         id_used,
  input  logic [31:0]          size,
  output logic                 found,
  output logic [$clog2(n)-1:0] base,
  output logic                 id_found,
  output logic [$clog2(n)-1:0] free_id
);
  localparam int IW = $clog2(n);

  int   sz;
  logic fit;

  always_comb begin
    found    = 1'b0;
    base     = '0;
    id_found = 1'b0;
    free_id  = '0;
    fit      = 1'b0;
    // oversize requests collapse to 0 so the window math never overflows
    sz       = (size > 32'(n)) ? 0 : int'(size);
    // scan downwards so the lowest fitting base / free id wins
    for (int b = n - 1; b >= 0; b--) begin
      fit = (sz != 0) && (sz <= n - b);
      for (int j = 0; j < n; j++)
        if (j >= b && j < b + sz && !free_mask[j]) fit = 1'b0;
      if (fit) begin
        found = 1'b1;
        base  = IW'(b);
      end
      if (!id_used[b]) begin
        id_found = 1'b1;
        free_id  = IW'(b);
      end
    end
  end
endmodule

// File: rtl/shared_counters_core.sv
// Pool of g-bit slices grouped into variable-width counters with increment, clear, free and serial read.
module shared_counters_core
  import shared_counters_pkg::*;
#(
  parameter int n = N_DEF,
  parameter int g = G_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [$clog2(n)-1:0]    id,
  input  logic [2:0]              command_in,
  input  logic [31:0]             new_counter_size,
  output logic [n-1:0][g-1:0]     data_out,
  output logic [$clog2(n):0]      allocation_id,
  output logic                    valid_allocation_id,
  output logic [g-1:0]            rdata_out,
  output logic                    valid_data_out,
  output logic                    last
);
  localparam int IW = $clog2(n);
  localparam int SW = $clog2(n + 1);

  logic [n-1:0][g-1:0]  slices, inc_val;
  logic [n-1:0]         used, id_valid, in_cnt;
  logic [n-1:0][IW-1:0] id_base;
  logic [n-1:0][SW-1:0] id_size;
  logic [IW-1:0]        sel_base, a_base, a_id, rd_base;
  logic [SW-1:0]        sel_size, rd_size, rd_idx;
  logic                 id_ok, carry, found, id_free, alloc_ok;
  rd_state_t            rd_state;
  cmd_t                 cmd;

  assign cmd      = cmd_t'(command_in);
  assign data_out = slices;
  assign alloc_ok = (cmd == CMD_NEW) && found && id_free;

  slice_allocator #(.n(n)) u_alloc (
    .free_mask(~used),
    .id_used  (id_valid),
    .size     (new_counter_size),
    .found    (found),
    .base     (a_base),
    .id_found (id_free),
    .free_id  (a_id)
  );

  // id lookup, slice membership and the carry chain across the selected counter
  always_comb begin
    id_ok    = 1'b0;
    sel_base = '0;
    sel_size = '0;
    for (int i = 0; i < n; i++)
      if (int'(id) == i) begin
        id_ok    = id_valid[i];
        sel_base = id_base[i];
        sel_size = id_size[i];
      end
    in_cnt  = '0;
    inc_val = slices;
    carry   = 1'b1;
    for (int s = 0; s < n; s++)
      if (s >= int'(sel_base) && s < int'(sel_base) + int'(sel_size)) begin
        in_cnt[s]  = 1'b1;
        inc_val[s] = slices[s] + {{(g-1){1'b0}}, carry};
        carry      = carry & (&slices[s]);
      end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      slices   <= '0;
      used     <= '0;
      id_valid <= '0;
      id_base  <= '0;
      id_size  <= '0;
    end else begin
      unique case (cmd)
        CMD_INC:  if (id_ok) slices <= inc_val;
        CMD_LOAD: if (id_ok)
          for (int s = 0; s < n; s++) if (in_cnt[s]) slices[s] <= '0;
        CMD_DEALLOC: if (id_ok) begin
          id_valid[id] <= 1'b0;
          for (int s = 0; s < n; s++)
            if (in_cnt[s]) begin
              used[s]   <= 1'b0;
              slices[s] <= '0;
            end
        end
        CMD_NEW: if (alloc_ok) begin
          id_valid[a_id] <= 1'b1;
          id_base[a_id]  <= a_base;
          id_size[a_id]  <= new_counter_size[SW-1:0];
          for (int s = 0; s < n; s++)
            if (s >= int'(a_base) && s < int'(a_base) + int'(new_counter_size[SW-1:0])) begin
              used[s]   <= 1'b1;
              slices[s] <= '0;
            end
        end
        default: ;
      endcase
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      allocation_id       <= '0;
      valid_allocation_id <= 1'b0;
    end else begin
      valid_allocation_id <= (cmd == CMD_NEW);
      if (cmd == CMD_NEW) allocation_id <= alloc_ok ? {1'b0, a_id} : '1;
    end

  // HOLD blocks a still-asserted read from starting a second burst
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_state <= RD_IDLE;
      rd_base  <= '0;
      rd_size  <= '0;
      rd_idx   <= '0;
    end else begin
      unique case (rd_state)
        RD_IDLE: if (cmd == CMD_READ && id_ok) begin
          rd_state <= RD_BURST;
          rd_base  <= sel_base;
          rd_size  <= sel_size;
          rd_idx   <= '0;
        end
        RD_BURST: if (rd_idx == rd_size - SW'(1)) rd_state <= RD_HOLD;
                  else rd_idx <= rd_idx + SW'(1);
        RD_HOLD:  if (cmd != CMD_READ) rd_state <= RD_IDLE;
        default:  rd_state <= RD_IDLE;
      endcase
    end

  assign valid_data_out = (rd_state == RD_BURST);
  assign last           = valid_data_out && (rd_idx == rd_size - SW'(1));

  always_comb begin
    rdata_out = '0;
    if (valid_data_out)
      for (int s = 0; s < n; s++)
        if (s == int'(rd_base) + int'(rd_idx)) rdata_out = slices[s];
  end
endmodule

// File: tb/tb_shared_counters_core.sv
// Bench for shared_counters_core: vector table, scoreboard queues for alloc ids and read beats, corner sequences.
module tb_shared_counters_core;
  import shared_counters_pkg::*;
  localparam int N = 10, G = 4, IW = ID_W;

  logic                clk = 1'b0, rst = 1'b1;
  logic [IW-1:0]       id = '0;
  logic [2:0]          command_in = '0;
  logic [31:0]         new_counter_size = '0;
  logic [N-1:0][G-1:0] data_out;
  logic [IW:0]         allocation_id;
  logic                valid_allocation_id, valid_data_out, last;
  logic [G-1:0]        rdata_out;

  int checks = 0, failures = 0;
  logic [IW:0] aq[$];
  logic [G:0]  rq[$];

  typedef struct {
    logic [2:0]     cmd;
    logic [IW-1:0]  vid;
    logic [31:0]    size;
    logic           vld;
    logic [IW:0]    aid;
    logic [N*G-1:0] data;
  } vec_t;
  vec_t vt[$];

  shared_counters_core #(.n(N), .g(G)) dut (
    .clk(clk), .rst(rst), .id(id), .command_in(command_in),
    .new_counter_size(new_counter_size), .data_out(data_out),
    .allocation_id(allocation_id), .valid_allocation_id(valid_allocation_id),
    .rdata_out(rdata_out), .valid_data_out(valid_data_out), .last(last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] c, input logic [IW-1:0] i, input logic [31:0] s,
                     input logic v, input logic [IW:0] a, input logic [N*G-1:0] d);
    vec_t e;
    e.cmd = c; e.vid = i; e.size = s; e.vld = v; e.aid = a; e.data = d;
    vt.push_back(e);
  endtask

  task automatic drive(input logic [2:0] c, input logic [IW-1:0] i, input int cycles);
    command_in = c; id = i;
    repeat (cycles) @(posedge clk);
    #1 command_in = CMD_IDLE;
  endtask

  // scoreboard side: every pulse must match the oldest queued expectation
  always @(negedge clk) if (rst) begin
    if (valid_allocation_id) begin
      if (aq.size() == 0) begin
        checks++; failures++;
        $display("FAIL alloc_unexpected actual=%0h expected=none", allocation_id);
      end else chk("alloc_id", 64'(allocation_id), 64'(aq.pop_front()));
    end
    if (valid_data_out) begin
      if (rq.size() == 0) begin
        checks++; failures++;
        $display("FAIL read_unexpected actual=%0h expected=none", {last, rdata_out});
      end else chk("read_beat", 64'({last, rdata_out}), 64'(rq.pop_front()));
    end else chk("read_idle", 64'({last, rdata_out}), 64'(0));
  end

  initial begin
    #2 rst = 1'b0;
    #2;
    chk("rst_data", 64'(data_out), 64'(0));
    chk("rst_aid", 64'(allocation_id), 64'(0));
    chk("rst_outs", 64'({valid_allocation_id, valid_data_out, last, rdata_out}), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    add(CMD_NEW, 0, 3, 1, 0, 40'h0);
    add(CMD_NEW, 0, 1, 1, 1, 40'h0);
    add(CMD_NEW, 0, 4, 1, 2, 40'h0);
    add(CMD_NEW, 0, 2, 1, 3, 40'h0);
    add(CMD_INC, 0, 0, 0, 0, 40'h00_0000_0001);
    add(CMD_INC, 1, 0, 0, 0, 40'h00_0000_1001);
    add(CMD_INC, 2, 0, 0, 0, 40'h00_0001_1001);
    add(CMD_INC, 3, 0, 0, 0, 40'h01_0001_1001);
    add(CMD_DEALLOC, 3, 0, 0, 0, 40'h00_0001_1001);
    add(CMD_DEALLOC, 4, 0, 0, 0, 40'h00_0001_1001);
    add(CMD_NEW, 0, 3, 1, 5'h1f, 40'h00_0001_1001);
    add(CMD_NEW, 0, 2, 1, 3, 40'h00_0001_1001);
    add(CMD_NEW, 0, 0, 1, 5'h1f, 40'h00_0001_1001);
    add(CMD_NEW, 0, 11, 1, 5'h1f, 40'h00_0001_1001);
    add(CMD_LOAD, 0, 0, 0, 0, 40'h00_0001_1000);
    add(CMD_LOAD, 1, 0, 0, 0, 40'h00_0001_0000);
    add(CMD_LOAD, 2, 0, 0, 0, 40'h0);
    add(CMD_INC, 12, 0, 0, 0, 40'h0);
    add(CMD_IDLE, 0, 0, 0, 0, 40'h0);

    for (int i = 0; i < vt.size(); i++) begin
      command_in = vt[i].cmd; id = vt[i].vid; new_counter_size = vt[i].size;
      if (vt[i].cmd == CMD_NEW) aq.push_back(vt[i].aid);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_vld", i), 64'(valid_allocation_id), 64'(vt[i].vld));
      chk($sformatf("vec%0d_data", i), 64'(data_out), 64'(vt[i].data));
    end
    command_in = CMD_IDLE;

    drive(CMD_INC, 0, 10000);
    chk("inc_10000", 64'(data_out), 64'h710);
    drive(CMD_INC, 1, 17);
    chk("inc_wrap", 64'(data_out), 64'h1710);

    rq.push_back({1'b0, 4'h0}); rq.push_back({1'b0, 4'h1}); rq.push_back({1'b1, 4'h7});
    drive(CMD_READ, 0, 5);
    repeat (4) @(posedge clk); #1;
    chk("read0_drained", 64'(rq.size()), 64'(0));

    rq.push_back({1'b1, 4'h1});
    drive(CMD_READ, 1, 1);
    repeat (3) @(posedge clk); #1;
    chk("read1_drained", 64'(rq.size()), 64'(0));

    drive(CMD_INC, 2, 3);
    chk("inc_id2", 64'(data_out), 64'h31710);
    rq.push_back({1'b0, 4'h3}); rq.push_back({1'b0, 4'h0});
    rq.push_back({1'b0, 4'h0}); rq.push_back({1'b1, 4'h0});
    drive(CMD_READ, 2, 1);
    drive(CMD_DEALLOC, 2, 1);
    chk("dealloc_mid_burst", 64'(data_out), 64'h01710);
    repeat (5) @(posedge clk); #1;
    chk("read2_drained", 64'(rq.size()), 64'(0));

    drive(CMD_LOAD, 0, 1);
    chk("load0", 64'(data_out), 64'h01000);
    drive(CMD_READ, 2, 2);
    repeat (4) @(posedge clk); #1;
    chk("unalloc_read_data", 64'(data_out), 64'h01000);

    command_in = CMD_READ; id = 0;
    @(posedge clk); #1;
    chk("burst_started", 64'({valid_data_out, last}), 64'b10);
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_data", 64'(data_out), 64'(0));
    chk("rst_mid_outs", 64'({allocation_id, valid_allocation_id, valid_data_out, last, rdata_out}), 64'(0));
    command_in = CMD_IDLE;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("queues_empty", 64'(aq.size() + rq.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shared_counters_core.md
# shared_counters_core

Pool of `n` equal `g`-bit counter slices that software-visible commands group into variable-width counters. A counter is `size` contiguous slices addressed by a counter id. It can be incremented, cleared, freed, or read out serially one slice per cycle. The block sits as a shared statistics resource. A controller issues one command per cycle.

## Interface
- `n`, 10: number of slices, which is also the maximum number of counter ids.
- `g`, 4: bits per slice.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `id` in `$clog2(n)`: counter id for increment, deallocate, load and read.
- `command_in` in 3: command code; 000 idle, 001 increment, 010 new_counter, 011 deallocate, 100 load, 101 read; 110 and 111 act as idle.
- `new_counter_size` in 32: number of slices requested by new_counter.
- `data_out` out `[n-1:0]` × `g`: live value of every slice.
- `allocation_id` out `$clog2(n)+1`: id granted by new_counter.
- `valid_allocation_id` out 1: one-cycle pulse qualifying `allocation_id`.
- `rdata_out` out `g`: serial read slice.
- `valid_data_out` out 1: qualifies `rdata_out`.
- `last` out 1: marks the final slice of a read burst.

## Operation
**State**
- Per slice: a free bit and a `g`-bit value.
- Per id: a valid bit, a base slice and a size.

**new_counter**
- Placement is first-fit: the lowest base with `size` contiguous free slices.
- The granted id is the lowest id whose valid bit is clear.
- On success: the slices are marked used and cleared to 0; `allocation_id` = the granted id.
- Failure cases: `size` is 0, `size` > `n`, no contiguous gap exists, or no id is free.
- On failure: `allocation_id` = all-ones, nothing changes.
- `valid_allocation_id` pulses in both the success and failure cases.

**increment**
- Counter `id` adds 1 on every cycle the command is present.
- The base slice is least significant; the carry ripples through the counter's slices within the same cycle.
- A counter of `size*g` bits wraps from all-ones to 0.
- Slices outside the counter are never touched.

**deallocate**
- The id is invalidated; its slices are marked free and cleared to 0.

**load**
- Counter `id` is cleared to 0. The id stays allocated.

**read**
- Emits the slices of counter `id` LSB-first, one per cycle.
- Values are live slice values at each output cycle.

**Invalid id**
- Increment, deallocate, load or read on an unallocated id is ignored: no state change and no output pulse.

**Read FSM**
- IDLE: moves to BURST when `command_in`=read and `id` is valid. The FSM latches the id's base and size, and the slice index = 0.
- BURST: outputs slice base+index each cycle.
  - When index = size-1, `last`=1 and the FSM moves to HOLD.
  - The burst always completes, whatever `command_in` does.
  - Other commands are still executed during a burst. A deallocate of the id being read does not abort the burst.
- HOLD: moves to IDLE when `command_in` ≠ read. One burst is produced per read assertion.

## Timing
- `command_in`, `id` and `new_counter_size` are sampled at posedge `clk`.
- Slice updates (increment, load, allocate, deallocate) are visible on `data_out` one cycle after the sampling edge.
- `valid_allocation_id` is registered and is high for exactly the one cycle after the new_counter edge.
  - A new_counter held for k cycles performs k allocations.
- Read latency:
  - The first `valid_data_out` appears one cycle after the read edge.
  - `valid_data_out` stays high for `size` consecutive cycles.
  - `last` is high together with the final one of those cycles.
  - `rdata_out` = 0 whenever `valid_data_out` = 0.
- Reset (asynchronous, `rst`=0):
  - All slices are 0 and free; all ids are invalid; the FSM is IDLE.
  - `data_out`, `allocation_id`, `valid_allocation_id`, `rdata_out`, `valid_data_out` and `last` are all 0.
  - Reset mid-burst aborts the burst immediately.

## Structure
- Shared package `shared_counters_pkg` holds:
  - `cmd_t`, the enum of the six command codes;
  - the read FSM state enum;
  - the localparam `ID_W = $clog2(n)`.
- One sub-module, `slice_allocator`: purely combinational first-fit search. It takes the free mask and the size, and returns found/base plus the lowest free id.
- Increment carry, the id table and the read FSM live in the top.

## Test plan
- Reset, then new_counter sizes 3, 1, 4, 2 → `allocation_id` 0, 1, 2, 3, each with a valid pulse; bases 0, 3, 4, 8; all slices used.
- deallocate 3 → slices 8–9 free; deallocate 4 (unallocated) → no change. Then new_counter 3 → `allocation_id` = all-ones (failure); new_counter 2 → id 3 at base 8.
- increment id 0 held for 10000 cycles → the 12-bit counter reads 10000 mod 4096 = 1808 (`data_out[2:0]` = 0111, 0001, 0000). Adjacent counter id 1 (slice 3) stays 0.
- Increment the 4-bit counter id 1 for 17 cycles → its value wraps to 1.
- read id 0 held for 5 cycles → `rdata_out` 0000, 0001, 0111 on 3 consecutive cycles, with `last` on the third; no second burst.
- load id 0 → its slices read 0. Read of an unallocated id → no `valid_data_out`. Async reset during a burst → all outputs 0 immediately.
